// File: rtl/checker_pkg.sv
// Shared definitions for the store-stream checker: verdict encodings, default
// program constants (also used by benches) and a saturating counter helper.
package checker_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [31:0] DEF_DONE_ADDR    = 32'd100;
  localparam logic [31:0] DEF_DONE_DATA    = 32'd7;
  localparam logic [31:0] DEF_SCRATCH_ADDR = 32'd96;
  localparam int          DEF_TIMEOUT      = 1000;
  localparam int          DEF_LOG_DEPTH    = 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/store_log_fifo.sv
// Store-log FIFO with registered read port and a sticky overflow flag.
// A push into a full FIFO survives only if a pop frees a slot on the same edge.
module store_log_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_overflow;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= w_do_pop;
      if (w_do_pop) begin
        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_push && !w_do_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/store_stream_checker.sv
// Judges a core's program from its data-memory store stream: PASS on the
// completion store, FAIL on any stray store, TIMEOUT when RUN lasts too long.
module store_stream_checker
  import checker_pkg::*;
#(
  parameter logic [31:0] DONE_ADDR    = DEF_DONE_ADDR,
  parameter logic [31:0] DONE_DATA    = DEF_DONE_DATA,
  parameter logic [31:0] SCRATCH_ADDR = DEF_SCRATCH_ADDR,
  parameter int          TIMEOUT      = DEF_TIMEOUT,
  parameter int          LOG_DEPTH    = DEF_LOG_DEPTH
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        log_rd_en,
  output logic [1:0]  state,
  output logic        done,
  output logic [15:0] store_count,
  output logic [15:0] cycle_count,
  output logic [31:0] fail_adr,
  output logic [31:0] fail_data,
  output logic        log_empty,
  output logic        log_overflow,
  output logic        log_valid,
  output logic [31:0] log_adr,
  output logic [31:0] log_data
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_store_count;
  logic [15:0] r_cycle_count;
  logic [31:0] r_fail_adr;
  logic [31:0] r_fail_data;

  logic        w_in_run;
  logic        w_accept;
  logic        w_done_store;
  logic        w_stray_store;
  logic [63:0] w_log_rd_data;

  assign w_in_run      = (r_state == ST_RUN);
  assign w_accept      = MemWrite && w_in_run;
  assign w_done_store  = (DataAdr == DONE_ADDR) && (WriteData == DONE_DATA);
  assign w_stray_store = (DataAdr != SCRATCH_ADDR);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A terminal store on the timeout edge takes precedence over TIMEOUT.
  always_comb begin
    w_state_nxt = r_state;
    if (w_in_run) begin
      if (w_accept && w_done_store) begin
        w_state_nxt = ST_PASS;
      end else if (w_accept && w_stray_store) begin
        w_state_nxt = ST_FAIL;
      end else if (r_cycle_count == TO_LAST) begin
        w_state_nxt = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_store_count <= '0;
      r_cycle_count <= '0;
      r_fail_adr    <= '0;
      r_fail_data   <= '0;
    end else begin
      if (w_in_run) begin
        r_cycle_count <= sat_inc16(r_cycle_count);
      end
      if (w_accept) begin
        r_store_count <= sat_inc16(r_store_count);
      end
      if (w_in_run && (w_state_nxt == ST_FAIL)) begin
        r_fail_adr  <= DataAdr;
        r_fail_data <= WriteData;
      end
    end
  end

  store_log_fifo #(
    .DATA_W (64),
    .DEPTH  (LOG_DEPTH)
  ) u_log (
    .clk         (clk),
    .rst         (Reset),
    .i_push      (w_accept),
    .i_push_data ({DataAdr, WriteData}),
    .i_pop       (log_rd_en),
    .o_rd_valid  (log_valid),
    .o_rd_data   (w_log_rd_data),
    .o_empty     (log_empty),
    .o_overflow  (log_overflow)
  );

  assign state       = r_state;
  assign done        = (r_state != ST_RUN);
  assign store_count = r_store_count;
  assign cycle_count = r_cycle_count;
  assign fail_adr    = r_fail_adr;
  assign fail_data   = r_fail_data;
  assign log_adr     = w_log_rd_data[63:32];
  assign log_data    = w_log_rd_data[31:0];

endmodule
